// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and instruction-word field helpers for the fetch stage.
package fetch_pkg;

    localparam int PC_W   = 8;
    localparam int OP_W   = 7;
    localparam int LIT_W  = 8;
    localparam int INSN_W = OP_W + LIT_W;

    localparam logic [OP_W-1:0] HALT_OPCODE = {OP_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    // Opcode occupies the high bits of the word, literal the low bits.
    function automatic logic [OP_W-1:0] insn_opcode(input logic [INSN_W-1:0] word);
        return word[INSN_W-1:LIT_W];
    endfunction

    function automatic logic [LIT_W-1:0] insn_literal(input logic [INSN_W-1:0] word);
        return word[LIT_W-1:0];
    endfunction

endpackage

// File: rtl/insn_fetch_pc.sv
// Program counter register: synchronous clear-to-zero and increment, wrapping modulo 2^PC_W.
module insn_fetch_pc
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: PC, req/ack instruction-memory read, valid/ready opcode+literal output.
// Optional FETCH_HALT_EN: an all-ones opcode stops fetching until the next start pulse.
module insn_fetch
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_data,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [OP_W-1:0]   opcode,
    output logic [LIT_W-1:0]  literal,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    fetch_state_e     state_q, state_d;
    logic [OP_W-1:0]  opcode_q, opcode_d;
    logic [LIT_W-1:0] literal_q, literal_d;
    logic             pc_clr, pc_inc;
    logic             is_halt;
    logic [PC_W-1:0]  pc_w;

`ifdef FETCH_HALT_EN
    assign is_halt = (insn_opcode(imem_data) == HALT_OPCODE);
`else
    assign is_halt = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        literal_d = literal_q;
        pc_clr    = 1'b0;
        pc_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    // A HALT word is swallowed: no presentation and no PC advance.
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else begin
                        opcode_d  = insn_opcode(imem_data);
                        literal_d = insn_literal(imem_data);
                        pc_inc    = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (insn_ready) state_d = ST_REQ;
            end
`ifdef FETCH_HALT_EN
            ST_HALT: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    state_d = ST_REQ;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            literal_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            literal_q <= literal_d;
        end
    end

    insn_fetch_pc u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pc_clr),
        .inc   (pc_inc),
        .pc    (pc_w)
    );

    // Handshake outputs are pure decodes of the state register.
    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = pc_w;
    assign pc         = pc_w;
    assign insn_valid = (state_q == ST_HOLD);
    assign opcode     = opcode_q;
    assign literal    = literal_q;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: table of fetch vectors plus hand-written start/halt/wrap/reset sequences.
module tb_insn_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [14:0] imem_data;
    logic        insn_valid;
    logic        insn_ready;
    logic [6:0]  opcode;
    logic [7:0]  literal;
    logic [7:0]  pc;
    logic        halted;

    insn_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .opcode     (opcode),
        .literal    (literal),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        int         dly;
        logic [7:0] addr;
        logic [6:0] op;
        logic [7:0] lit;
    } vec_t;

    vec_t        vecs[5];
    logic [14:0] mem[256];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_lat = 0;
    int          wait_cnt = 0;
    bit          ready_val = 0;
    bit          manual = 0;
    bit          sb_en = 0;
    logic [7:0]  sb_addr = 8'd0;
    int          n_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive memory response and ready, advance, then scoreboard any accepted word.
    task automatic tick();
        bit          acc;
        logic [14:0] word;
        if (!manual) begin
            if (imem_req) begin
                if (wait_cnt >= ack_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    wait_cnt  = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
        insn_ready = ready_val;
        acc  = insn_valid && insn_ready;
        word = {opcode, literal};
        @(posedge clk);
        #1;
        if (acc) begin
            n_acc++;
            if (sb_en) begin
                chk("sb_word", 32'(word), 32'(mem[sb_addr]));
                sb_addr = sb_addr + 8'd1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0; insn_ready = 1'b0;
        ready_val = 0; manual = 0; wait_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fetch_one(input vec_t v);
        logic [6:0] op0;
        logic [7:0] lit0;
        ack_lat = v.lat;
        ready_val = 0;
        for (int i = 0; i < 50 && !insn_valid; i++) begin
            if (imem_req) chk("addr_stable", 32'(imem_addr), 32'(v.addr));
            tick();
        end
        chk("valid", 32'(insn_valid), 32'd1);
        chk("opcode", 32'(opcode), 32'(v.op));
        chk("literal", 32'(literal), 32'(v.lit));
        chk("pc_inc", 32'(pc), 32'(v.addr + 8'd1));
        chk("halted_low", 32'(halted), 32'd0);
        op0 = opcode; lit0 = literal;
        for (int i = 0; i < v.dly; i++) begin
            tick();
            chk("hold_op", 32'(opcode), 32'(op0));
            chk("hold_lit", 32'(literal), 32'(lit0));
            chk("hold_noreq", 32'(imem_req), 32'd0);
        end
        ready_val = 1;
        tick();
        ready_val = 0;
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_addr", 32'(imem_addr), 32'(v.addr + 8'd1));
        $display("[TB] fetch addr=%0h op=%0h lit=%0h lat=%0d dly=%0d", v.addr, v.op, v.lit, v.lat, v.dly);
    endtask

    initial begin
        bit saw_wrap;
        for (int i = 0; i < 256; i++) mem[i] = {7'(i % 112), 8'(i ^ 8'h5A)};
        mem[0] = 15'h0205; mem[1] = 15'h0A33; mem[2] = 15'h11AA; mem[3] = 15'h7F00; mem[4] = 15'h0C01;
        vecs[0] = '{lat: 3, dly: 4, addr: 8'd1, op: 7'h0A, lit: 8'h33};
        vecs[1] = '{lat: 1, dly: 0, addr: 8'd2, op: 7'h11, lit: 8'hAA};
        vecs[2] = '{lat: 0, dly: 2, addr: 8'd3, op: 7'h7F, lit: 8'h00};
        vecs[3] = '{lat: 2, dly: 1, addr: 8'd4, op: 7'h0C, lit: 8'h01};
        vecs[4] = '{lat: 0, dly: 1, addr: 8'd0, op: 7'h02, lit: 8'h05};

        do_reset();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_valid", 32'(insn_valid), 32'd0);
        chk("rst_op", 32'(opcode), 32'd0);
        chk("rst_lit", 32'(literal), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        tick();
        chk("idle_noreq", 32'(imem_req), 32'd0);

        // Zero-wait start sequence with ready held high.
        ack_lat = 0; ready_val = 1;
        pulse_start();
        chk("start_req", 32'(imem_req), 32'd1);
        chk("start_addr", 32'(imem_addr), 32'd0);
        tick();
        chk("zw_valid", 32'(insn_valid), 32'd1);
        chk("zw_op", 32'(opcode), 32'h02);
        chk("zw_lit", 32'(literal), 32'h05);
        chk("zw_pc", 32'(pc), 32'd1);
        tick();
        chk("zw_next_req", 32'(imem_req), 32'd1);
        chk("zw_next_addr", 32'(imem_addr), 32'd1);
        $display("[TB] zero-wait fetch addr=0 op=02 lit=05");
        ready_val = 0;

`ifdef FETCH_HALT_EN
        for (int i = 0; i < 2; i++) fetch_one(vecs[i]);
        ack_lat = 0;
        tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd3);
        chk("halt_valid", 32'(insn_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_noreq", 32'(imem_req), 32'd0);
        end
        pulse_start();
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd0);
        chk("resume_halted", 32'(halted), 32'd0);
        $display("[TB] halt at addr=3, resumed at 0");
        fetch_one(vecs[4]);
`else
        for (int i = 0; i < 4; i++) fetch_one(vecs[i]);
`endif

        // PC wrap: stream 257 words back-to-back from address 0.
        do_reset();
        mem[3] = 15'h0C03;
        sb_en = 1; sb_addr = 8'd0; n_acc = 0; saw_wrap = 0;
        ack_lat = 0; ready_val = 1;
        pulse_start();
        for (int i = 0; i < 1000 && n_acc < 257; i++) begin
            if (imem_req && imem_addr == 8'd0 && n_acc == 256) saw_wrap = 1;
            tick();
        end
        sb_en = 0; ready_val = 0;
        chk("wrap_count", 32'(n_acc), 32'd257);
        chk("wrap_seen", 32'(saw_wrap), 32'd1);
        chk("wrap_pc", 32'(pc), 32'd1);
        $display("[TB] wrap stream accepted=%0d", n_acc);

        // Reset while a read is pending, then a stale ack.
        ack_lat = 100;
        pulse_start();
        tick();
        chk("pend_req", 32'(imem_req), 32'd1);
        manual = 1; imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", 32'(imem_addr), 32'd0);
        chk("mr_pc", 32'(pc), 32'd0);
        chk("mr_valid", 32'(insn_valid), 32'd0);
        chk("mr_op", 32'(opcode), 32'd0);
        chk("mr_lit", 32'(literal), 32'd0);
        chk("mr_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b1; imem_data = 15'h0205;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("late_ack_valid", 32'(insn_valid), 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd0);
        chk("late_ack_pc", 32'(pc), 32'd0);
        $display("[TB] reset mid-request, late ack ignored");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_fetch.md
# insn_fetch

Instruction fetch stage sitting directly upstream of the opcode decoder/control unit. Holds the program counter, issues word reads to instruction memory through a req/ack handshake, and presents each fetched word as a 7-bit opcode plus 8-bit literal (k8) under a valid/ready handshake. The decoder drives LA/LB/SA/SB/alu_s from the opcode while the datapath consumes the literal.

## Interface
- PC_W, 8: program counter and instruction-memory address width
- OP_W, 7: opcode field width; must match the decoder input
- LIT_W, 8: literal field width; must match the datapath k8 operand
- Instruction word width is OP_W+LIT_W (15 at defaults): opcode in the high bits, literal in the low bits.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse that begins or restarts fetching
- imem_req  out  1  read request to instruction memory
- imem_addr  out  PC_W  read address, equal to the current PC
- imem_ack  in  1  read data valid this cycle
- imem_data  in  OP_W+LIT_W  instruction word, sampled when imem_ack=1
- insn_valid  out  1  opcode/literal hold a fetched instruction
- insn_ready  in  1  decoder/datapath accepts the instruction this cycle
- opcode  out  OP_W  opcode field of the held instruction
- literal  out  LIT_W  literal field of the held instruction
- pc  out  PC_W  address of the next word to fetch
- halted  out  1  fetch stopped on a HALT word (see Configuration)

## Operation
- FSM states: IDLE, REQ, HOLD, HALT.
- IDLE: all handshake outputs are low. If start=1, go to REQ.
- REQ: imem_req=1 and imem_addr=pc. On imem_ack=1, latch imem_data into the instruction register, set pc to pc+1, and go to HOLD.
- HOLD: insn_valid=1. If insn_ready=1, go to REQ.
- HALT: halted=1, with no requests and no valid output. If start=1, clear halted, set pc to 0, and go to REQ.
- PC wraps modulo 2^PC_W, so 0xFF+1 is 0x00 with no flag.
- start in REQ or HOLD is ignored. imem_ack outside REQ is ignored.
- In IDLE, start fetches from the current pc, which is 0 after reset.
- Words are never dropped or duplicated: each acked word is presented exactly once.

## Timing
- All outputs come from registers: no combinational path from any input to any output.
- Reset values: imem_req=0, imem_addr=0, pc=0, insn_valid=0, opcode=0, literal=0, halted=0, state=IDLE.
- imem_req rises on the cycle after start is sampled. imem_req and imem_addr stay stable until the ack is sampled.
- imem_ack may arrive in the same cycle imem_req is first high (zero wait) or any number of cycles later.
- insn_valid rises on the cycle after the ack. opcode and literal stay stable while insn_valid=1 and insn_ready=0.
- Best-case throughput is one instruction per 2 cycles: one REQ cycle with immediate ack, then one HOLD cycle with ready=1.
- If rst_n is asserted mid-request, the state returns to IDLE and the pending read is abandoned. A late imem_ack arriving after reset is ignored.

## Configuration
- FETCH_HALT_EN defined:
  - An acked word whose opcode is all ones (7'b1111111) is not presented.
  - pc is not incremented for that word.
  - The FSM enters HALT and halted=1 on the next cycle.
- FETCH_HALT_EN undefined:
  - The HALT state and the halted register are removed, and halted is tied to 0.
  - The all-ones opcode is presented like any other word; the decoder treats it as a no-op.

## Structure
- fetch_pkg holds:
  - PC_W, OP_W and LIT_W default constants
  - the fetch state enum
  - the HALT_OPCODE constant (all ones, OP_W bits)
  - field-slice helper functions that split an instruction word into opcode and literal
- One sub-module, insn_fetch_pc: the PC register with load-zero and increment-enable inputs and modulo wrap.

## Test plan
- Reset, start, zero-wait memory, insn_ready held at 1, word 0x0205 at address 0: imem_req rises 1 cycle after start; opcode=0x02 (MOV A,Lit) and literal=0x05 with insn_valid=1 one cycle after the ack; pc=1; next imem_req follows immediately.
- Memory acks 3 cycles late and insn_ready stays low for 4 cycles: imem_addr is stable throughout; opcode and literal hold; no second request is issued until ready.
- pc preloaded to 0xFF by fetching 256 words: pc wraps to 0x00 and the word at address 0 is fetched again.
- With FETCH_HALT_EN defined, word 0x7F00 at address 3: three instructions are presented, then halted=1 with pc=3 and no further imem_req. A start pulse resumes fetching at address 0.
- Without FETCH_HALT_EN, the same program: 0x7F00 is presented as opcode 0x7F, halted stays 0, and fetching continues.
- rst_n pulsed low while in REQ with the ack pending: all outputs return to 0 and the state is IDLE. An ack in the following cycle produces no insn_valid.
